// File: rtl/rank_filter_pkg.sv
// rtl/rank_filter_pkg.sv - shared types and constants for the 3x3 rank filter
package rank_filter_pkg;

  typedef enum logic [1:0] {
    RANK_MIN = 2'd0,
    RANK_MED = 2'd1,
    RANK_MAX = 2'd2
  } rank_t;

  // Accepted pixel to matching output, no stall.
  localparam int RANK_FILTER_LAT = 4;

  // Rows/columns below this index lack a full 3x3 neighbourhood.
  localparam int BORDER_TH = 2;

  // rank_sel encoding 3 is an alias of median.
  function automatic rank_t decode_rank(input logic [1:0] sel);
    case (sel)
      2'd0:    return RANK_MIN;
      2'd2:    return RANK_MAX;
      default: return RANK_MED;
    endcase
  endfunction

endpackage

// File: rtl/sort3.sv
// rtl/sort3.sv - combinational unsigned sort of three values
// Ports: a, b, c  - unsorted inputs
//        lo/mid/hi - the same values in ascending order
module sort3 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] hi
);

  logic [DATA_W-1:0] ab_lo;
  logic [DATA_W-1:0] ab_hi;

  always_comb begin
    ab_lo = (a < b) ? a : b;
    ab_hi = (a < b) ? b : a;
    if (c < ab_lo) begin
      lo  = c;
      mid = ab_lo;
      hi  = ab_hi;
    end else if (c < ab_hi) begin
      lo  = ab_lo;
      mid = c;
      hi  = ab_hi;
    end else begin
      lo  = ab_lo;
      mid = ab_hi;
      hi  = c;
    end
  end

endmodule

// File: rtl/rank_filter_3x3.sv
// rtl/rank_filter_3x3.sv - streaming 3x3 min/median/max filter, 4-stage pipeline
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_data/in_sof - raster pixel stream in
//        rank_sel - 0 min, 1/3 median, 2 max; sampled on accepted in_sof
//        out_valid/out_ready/out_data/out_sof - filtered stream, one per input
// Build option: RANK_FILTER_BORDER_PASS_EN - border pixels pass the raw input
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic [1:0]        rank_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic stall, accept;
  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  rank_t rank_q, rank_d, pix_rank;

  pix_t lb0_mem [IMG_W];
  pix_t lb1_mem [IMG_W];
  pix_t lb0_rd, lb1_rd;

  // S1: sliding window [row][col], column 2 is newest.
  pix_t  win_q [3][3], win_d [3][3];
  logic  s1_valid_q, s1_valid_d, s1_border_q, s1_border_d, s1_sof_q, s1_sof_d;
  rank_t s1_rank_q, s1_rank_d;

  // S2: per-column sorted values.
  pix_t  col_lo [3], col_mid [3], col_hi [3];
  pix_t  s2_lo_q [3], s2_lo_d [3], s2_mid_q [3], s2_mid_d [3], s2_hi_q [3], s2_hi_d [3];
  logic  s2_valid_q, s2_valid_d, s2_border_q, s2_border_d, s2_sof_q, s2_sof_d;
  rank_t s2_rank_q, s2_rank_d;

  // S3: min / max plus the three median candidates.
  pix_t  s3_min_q, s3_min_d, s3_max_q, s3_max_d;
  pix_t  s3_a_q, s3_a_d, s3_b_q, s3_b_d, s3_c_q, s3_c_d;
  logic  s3_valid_q, s3_valid_d, s3_border_q, s3_border_d, s3_sof_q, s3_sof_d;
  rank_t s3_rank_q, s3_rank_d;

`ifdef RANK_FILTER_BORDER_PASS_EN
  pix_t s2_raw_q, s2_raw_d, s3_raw_q, s3_raw_d;
`endif

  // S4 / output register.
  pix_t s4_med, s4_unused_lo, s4_unused_hi, border_val, s4_result;
  logic out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  pix_t out_data_q, out_data_d;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && !stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;

  // An accepted in_sof restarts the frame at (0,0) regardless of the counters.
  assign pos_col  = in_sof ? '0 : col_q;
  assign pos_row  = in_sof ? '0 : row_q;
  assign pix_rank = in_sof ? decode_rank(rank_sel) : rank_q;
  assign lb0_rd   = lb0_mem[pos_col];
  assign lb1_rd   = lb1_mem[pos_col];

  for (genvar c = 0; c < 3; c++) begin : g_col_sort
    sort3 #(.DATA_W(DATA_W)) u_sort (
      .a  (win_q[0][c]),
      .b  (win_q[1][c]),
      .c  (win_q[2][c]),
      .lo (col_lo[c]),
      .mid(col_mid[c]),
      .hi (col_hi[c])
    );
  end

  sort3 #(.DATA_W(DATA_W)) u_med_sort (
    .a  (s3_a_q),
    .b  (s3_b_q),
    .c  (s3_c_q),
    .lo (s4_unused_lo),
    .mid(s4_med),
    .hi (s4_unused_hi)
  );

  always_comb begin
`ifdef RANK_FILTER_BORDER_PASS_EN
    border_val = s3_raw_q;
`else
    border_val = '0;
`endif
    if (s3_border_q)                s4_result = border_val;
    else if (s3_rank_q == RANK_MIN) s4_result = s3_min_q;
    else if (s3_rank_q == RANK_MAX) s4_result = s3_max_q;
    else                            s4_result = s4_med;
  end

  always_comb begin
    col_d = col_q;  row_d = row_q;  rank_d = rank_q;  win_d = win_q;
    s1_valid_d = s1_valid_q;  s1_border_d = s1_border_q;  s1_sof_d = s1_sof_q;  s1_rank_d = s1_rank_q;
    s2_valid_d = s2_valid_q;  s2_border_d = s2_border_q;  s2_sof_d = s2_sof_q;  s2_rank_d = s2_rank_q;
    s2_lo_d = s2_lo_q;  s2_mid_d = s2_mid_q;  s2_hi_d = s2_hi_q;
    s3_valid_d = s3_valid_q;  s3_border_d = s3_border_q;  s3_sof_d = s3_sof_q;  s3_rank_d = s3_rank_q;
    s3_min_d = s3_min_q;  s3_max_d = s3_max_q;  s3_a_d = s3_a_q;  s3_b_d = s3_b_q;  s3_c_d = s3_c_q;
`ifdef RANK_FILTER_BORDER_PASS_EN
    s2_raw_d = s2_raw_q;  s3_raw_d = s3_raw_q;
`endif
    out_valid_d = out_valid_q;  out_data_d = out_data_q;  out_sof_d = out_sof_q;

    if (accept) begin
      if (pos_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      if (in_sof) rank_d = pix_rank;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = in_data;
      s1_border_d = (pos_row < RW'(BORDER_TH)) || (pos_col < CW'(BORDER_TH));
      s1_sof_d    = in_sof;
      s1_rank_d   = pix_rank;
    end

    // Every stage advances together unless the output is blocked.
    if (!stall) begin
      s1_valid_d  = accept;
      s2_valid_d  = s1_valid_q;
      s2_border_d = s1_border_q;
      s2_sof_d    = s1_sof_q;
      s2_rank_d   = s1_rank_q;
      s2_lo_d     = col_lo;
      s2_mid_d    = col_mid;
      s2_hi_d     = col_hi;
      s3_valid_d  = s2_valid_q;
      s3_border_d = s2_border_q;
      s3_sof_d    = s2_sof_q;
      s3_rank_d   = s2_rank_q;
      s3_min_d    = min2(min2(s2_lo_q[0], s2_lo_q[1]), s2_lo_q[2]);
      s3_max_d    = max2(max2(s2_hi_q[0], s2_hi_q[1]), s2_hi_q[2]);
      s3_a_d      = max2(max2(s2_lo_q[0], s2_lo_q[1]), s2_lo_q[2]);
      s3_b_d      = med3(s2_mid_q[0], s2_mid_q[1], s2_mid_q[2]);
      s3_c_d      = min2(min2(s2_hi_q[0], s2_hi_q[1]), s2_hi_q[2]);
`ifdef RANK_FILTER_BORDER_PASS_EN
      s2_raw_d    = win_q[2][2];
      s3_raw_d    = s2_raw_q;
`endif
      out_valid_d = s3_valid_q;
      out_data_d  = s3_valid_q ? s4_result : '0;
      out_sof_d   = s3_valid_q && s3_sof_q;
    end
  end

  // Line buffers are never reset; the border mask hides stale rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[pos_col] <= lb1_rd;
      lb1_mem[pos_col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;  row_q <= '0;  rank_q <= RANK_MED;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      for (int c = 0; c < 3; c++) begin
        s2_lo_q[c] <= '0;  s2_mid_q[c] <= '0;  s2_hi_q[c] <= '0;
      end
      s1_valid_q <= 1'b0;  s1_border_q <= 1'b0;  s1_sof_q <= 1'b0;  s1_rank_q <= RANK_MED;
      s2_valid_q <= 1'b0;  s2_border_q <= 1'b0;  s2_sof_q <= 1'b0;  s2_rank_q <= RANK_MED;
      s3_valid_q <= 1'b0;  s3_border_q <= 1'b0;  s3_sof_q <= 1'b0;  s3_rank_q <= RANK_MED;
      s3_min_q <= '0;  s3_max_q <= '0;  s3_a_q <= '0;  s3_b_q <= '0;  s3_c_q <= '0;
`ifdef RANK_FILTER_BORDER_PASS_EN
      s2_raw_q <= '0;  s3_raw_q <= '0;
`endif
      out_valid_q <= 1'b0;  out_data_q <= '0;  out_sof_q <= 1'b0;
    end else begin
      col_q <= col_d;  row_q <= row_d;  rank_q <= rank_d;  win_q <= win_d;
      s2_lo_q <= s2_lo_d;  s2_mid_q <= s2_mid_d;  s2_hi_q <= s2_hi_d;
      s1_valid_q <= s1_valid_d;  s1_border_q <= s1_border_d;  s1_sof_q <= s1_sof_d;  s1_rank_q <= s1_rank_d;
      s2_valid_q <= s2_valid_d;  s2_border_q <= s2_border_d;  s2_sof_q <= s2_sof_d;  s2_rank_q <= s2_rank_d;
      s3_valid_q <= s3_valid_d;  s3_border_q <= s3_border_d;  s3_sof_q <= s3_sof_d;  s3_rank_q <= s3_rank_d;
      s3_min_q <= s3_min_d;  s3_max_q <= s3_max_d;  s3_a_q <= s3_a_d;  s3_b_q <= s3_b_d;  s3_c_q <= s3_c_d;
`ifdef RANK_FILTER_BORDER_PASS_EN
      s2_raw_q <= s2_raw_d;  s3_raw_q <= s3_raw_d;
`endif
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;  out_sof_q <= out_sof_d;
    end
  end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb/tb_rank_filter_3x3.sv - self-checking bench for rank_filter_3x3 (8x8 frames)
module tb_rank_filter_3x3;
  import rank_filter_pkg::*;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic [1:0]    rank_sel = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sof;

  always #5 clk = ~clk;

  rank_filter_3x3 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .rank_sel (rank_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
  } exp_t;

  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            first_acc = -1;
  int            first_out = -1;
  logic [DW-1:0] img [IH][IW];
  int            m_row = 0;
  int            m_col = 0;
  int            m_rank = 1;
  exp_t          exp_q [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_sof = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Reference: rank of the 3x3 neighbourhood ending at (r,c) in the image seen so far.
  function automatic logic [DW-1:0] ref_out(input int r, input int c, input int rk);
    int v [9];
    int n;
    int t;
    if (r < BORDER_TH || c < BORDER_TH) begin
`ifdef RANK_FILTER_BORDER_PASS_EN
      return img[r][c];
`else
      return '0;
`endif
    end
    n = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v[n] = int'(img[r-dr][c-dc]);
        n++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    if (rk == 0) return DW'(v[0]);
    if (rk == 2) return DW'(v[8]);
    return DW'(v[4]);
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic s, input logic [1:0] rs);
    if (s) begin
      m_row = 0;
      m_col = 0;
      m_rank = (rs == 2'd0) ? 0 : (rs == 2'd2) ? 2 : 1;
    end
    img[m_row][m_col] = d;
    exp_q.push_back({ref_out(m_row, m_col, m_rank), s});
    if (first_acc < 0) first_acc = cyc;
    m_col++;
    if (m_col == IW) begin
      m_col = 0;
      m_row = (m_row == IH - 1) ? 0 : m_row + 1;
    end
  endtask

  // One clock: drive at negedge, observe 1 ns later, return on the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic s, input logic [1:0] rs,
                      input logic ordy, output logic acc);
    exp_t e;
    logic stall_now;
    in_valid = v; in_data = d; in_sof = s; rank_sel = rs; out_ready = ordy;
    #1;
    stall_now = out_valid && !out_ready;
    check("in_ready_vs_stall", 32'(in_ready), 32'(!stall_now));
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
      check("hold_sof", 32'(out_sof), 32'(prev_sof));
    end
    if (out_valid && first_out < 0) first_out = cyc;
    if (out_valid && out_ready) begin
      check("output_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sof", 32'(out_sof), 32'(e.sof));
      end
    end
    acc = v && in_ready;
    if (acc) model_accept(d, s, rs);
    prev_stall = stall_now;
    prev_data = out_data;
    prev_sof = out_sof;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_px(input logic [DW-1:0] d, input logic s, input logic [1:0] rs,
                         input int pv, input int pr);
    logic acc;
    logic v;
    int   budget;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      v = ($urandom_range(99) < pv);
      step(v, d, s, rs, ($urandom_range(99) < pr), acc);
      budget++;
    end
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int pr);
    logic acc;
    int   budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      step(1'b0, '0, 1'b0, 2'd0, ($urandom_range(99) < pr), acc);
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [DW-1:0] pat(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'h55;
      1:       return (r == 4 && c == 4) ? 8'hFF : 8'h00;
      2:       return DW'(c * 16);
      default: return DW'($urandom_range(255));
    endcase
  endfunction

  // rest < 0: random rank_sel on non-first pixels (must be ignored by the latch).
  task automatic send_frame(input int kind, input logic [1:0] rs_first, input int rest,
                            input int pv, input int pr);
    logic [1:0] rs;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        rs = (r == 0 && c == 0) ? rs_first : (rest < 0) ? 2'($urandom_range(3)) : 2'(rest);
        send_px(pat(kind, r, c), (r == 0 && c == 0), rs, pv, pr);
      end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sof", 32'(out_sof), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant frame, median, no backpressure; first output LAT cycles after first accept.
    send_frame(0, 2'd1, 1, 100, 100);
    check("latency", 32'(first_out - first_acc), 32'(RANK_FILTER_LAT));
    drain(100);

    // Impulse at (4,4): median, max, min.
    send_frame(1, 2'd1, -1, 100, 100);
    send_frame(1, 2'd2, -1, 100, 100);
    send_frame(1, 2'd0, -1, 100, 100);
    drain(100);

    // Ramp with min; rank_sel flips to max mid-frame without in_sof.
    send_frame(2, 2'd0, 2, 100, 100);
    drain(100);

    // Random data, random gaps and backpressure.
    send_frame(3, 2'($urandom_range(3)), -1, 70, 50);
    send_frame(3, 2'($urandom_range(3)), -1, 70, 50);
    drain(50);

    // Resync: in_sof on pixel 5 of line 3, then three more lines.
    send_px(8'h11, 1'b1, 2'd1, 80, 60);
    for (int i = 1; i < 3 * IW + 5 + 3 * IW; i++)
      send_px(DW'($urandom_range(255)), (i == 3 * IW + 5), 2'd2, 80, 60);
    drain(60);

    // Reset while the pipeline is busy.
    send_px(DW'($urandom_range(255)), 1'b1, 2'd2, 100, 100);
    for (int i = 1; i < 20; i++)
      send_px(DW'($urandom_range(255)), 1'b0, 2'd2, 100, 100);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_sof", 32'(out_sof), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    m_rank = 1;
    prev_stall = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    // No in_sof: treated as (0,0) with the reset-default median rank.
    for (int i = 0; i < 5 * IW; i++)
      send_px(DW'($urandom_range(255)), 1'b0, 2'd0, 80, 60);
    drain(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
